// File: rtl/wb_master_initiator.sv
// Wishbone classic-cycle initiator: takes one read/write command at a time,
// runs a single Wishbone cycle for it, and returns the data/status on a
// valid/ready response port. A saturating counter aborts cycles the slave
// never answers.
module wb_master_initiator #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  // command port
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [WB_ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel,
  input  logic [WB_DATA_WIDTH-1:0]   cmd_dat,
  // response port
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]   rsp_dat,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  // Wishbone master side
  output logic                       CYC,
  output logic                       STB,
  output logic                       WE,
  output logic [WB_ADDR_WIDTH-1:0]   ADR,
  output logic [WB_DATA_WIDTH/8-1:0] SEL,
  output logic [WB_DATA_WIDTH-1:0]   DAT_W,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       ACK,
  input  logic                       ERR
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;

  // The counter holds the number of no-response edges already seen in BUS,
  // so the abort fires on the edge where it equals TIMEOUT_CYCLES-1; that
  // leaves CYC high for exactly TIMEOUT_CYCLES cycles.
  localparam int          TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [15:0] TO_LAST   = TO_LAST_I[15:0];
  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RSP
  } state_t;

  state_t                     state, state_nxt;
  logic [15:0]                cnt, cnt_nxt;
  logic                       cyc_nxt, stb_nxt, we_nxt;
  logic [WB_ADDR_WIDTH-1:0]   adr_nxt;
  logic [SEL_W-1:0]           sel_nxt;
  logic [WB_DATA_WIDTH-1:0]   datw_nxt;
  logic                       rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [WB_DATA_WIDTH-1:0]   rsp_dat_nxt;

  // Commands are only taken while no transaction is outstanding.
  assign cmd_ready = (state == S_IDLE);

  // State, bus and response registers; everything returns to zero/IDLE on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      CYC         <= 1'b0;
      STB         <= 1'b0;
      WE          <= 1'b0;
      ADR         <= '0;
      SEL         <= '0;
      DAT_W       <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_dat     <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      CYC         <= cyc_nxt;
      STB         <= stb_nxt;
      WE          <= we_nxt;
      ADR         <= adr_nxt;
      SEL         <= sel_nxt;
      DAT_W       <= datw_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      rsp_dat     <= rsp_dat_nxt;
    end
  end

  // Next-state and next-output logic; every register holds unless a state acts.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    cyc_nxt         = CYC;
    stb_nxt         = STB;
    we_nxt          = WE;
    adr_nxt         = ADR;
    sel_nxt         = SEL;
    datw_nxt        = DAT_W;
    rsp_valid_nxt   = rsp_valid;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    rsp_dat_nxt     = rsp_dat;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = S_BUS;
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          we_nxt    = cmd_we;
          adr_nxt   = cmd_adr;
          sel_nxt   = cmd_sel;
          datw_nxt  = cmd_we ? cmd_dat : '0;
          cnt_nxt   = '0;
        end
      end

      S_BUS: begin
        if (ERR) begin
          // ERR takes priority over a simultaneous ACK.
          state_nxt       = S_RSP;
          cyc_nxt         = 1'b0;
          stb_nxt         = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b0;
          rsp_dat_nxt     = '0;
        end else if (ACK) begin
          state_nxt       = S_RSP;
          cyc_nxt         = 1'b0;
          stb_nxt         = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
          rsp_dat_nxt     = WE ? '0 : DAT_R;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          state_nxt       = S_RSP;
          cyc_nxt         = 1'b0;
          stb_nxt         = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_dat_nxt     = '0;
        end else if (cnt != 16'hFFFF) begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          state_nxt       = S_IDLE;
          rsp_valid_nxt   = 1'b0;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
